// File: rtl/delay_pkg.sv
// Shared helpers for the delay line: tap width derivation and channel slice offset.
package delay_pkg;

   function automatic int tap_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Bit offset of channel k in a packed multi-channel word.
   function automatic int ch_lsb(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/delay_stage.sv
// One delay-line stage: a single register holding {valid, data}, valid in the MSB.
module delay_stage #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // NOTE: sequential state uses non-blocking assignments; the later valid-bit clear
   // overrides the shifted-in valid within the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else begin
         if (ce)  q <= d;
         if (clr) q[W-1] <= 1'b0;
      end
   end

endmodule

// File: rtl/delay_line.sv
// Multi-channel tapped delay line with clock enable and flush.
// Optional macro DELAY_LINE_PRIMED_EN adds a fill counter and the primed output.
module delay_line
   import delay_pkg::*;
#(
   parameter  int DATA_W    = 8,
   parameter  int CH        = 1,
   parameter  int MAX_DEPTH = 8,
   localparam int TAP_W     = tap_width(MAX_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce,
   input  logic                 flush,
   input  logic [TAP_W-1:0]     tap,
   input  logic [CH*DATA_W-1:0] idata,
   input  logic                 ivalid,
   output logic [CH*DATA_W-1:0] odata,
   output logic                 ovalid
`ifdef DELAY_LINE_PRIMED_EN
   ,
   output logic                 primed
`endif
);

   localparam int               SW   = CH * DATA_W + 1;
   localparam logic [TAP_W-1:0] LAST = TAP_W'(MAX_DEPTH - 1);

   logic [SW-1:0]    stage_q [MAX_DEPTH];
   logic [TAP_W-1:0] sel;
   logic [SW-1:0]    sel_q;

   // NOTE: every stage, data included, is reset so no stale sample can reach odata after rst.
   for (genvar i = 0; i < MAX_DEPTH; i++) begin : g_stage
      logic [SW-1:0] d;
      if (i == 0) begin : g_head
         assign d = {ivalid, idata};
      end else begin : g_link
         assign d = stage_q[i-1];
      end
      delay_stage #(.W(SW)) u_stage (
         .clk (clk),
         .rst (rst),
         .ce  (ce),
         .clr (flush),
         .d   (d),
         .q   (stage_q[i])
      );
   end

   // Taps beyond the last stage (non-power-of-2 depth) read the last stage.
   // NOTE: the select has a value on every path, so no latch is inferred.
   always_comb begin
      sel   = (tap >= LAST) ? LAST : tap;
      sel_q = stage_q[sel];
   end

   assign ovalid = sel_q[SW-1];

   for (genvar k = 0; k < CH; k++) begin : g_ch
      assign odata[ch_lsb(k, DATA_W) +: DATA_W] = sel_q[ch_lsb(k, DATA_W) +: DATA_W];
   end

`ifdef DELAY_LINE_PRIMED_EN
   localparam int FILL_W = $clog2(MAX_DEPTH + 1);

   logic [FILL_W-1:0] fill_q;
   logic [FILL_W-1:0] need;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         fill_q <= '0;
      end else if (ce && ivalid && (fill_q != FILL_W'(MAX_DEPTH))) begin
         fill_q <= fill_q + FILL_W'(1);
      end
   end

   assign need   = FILL_W'(sel) + FILL_W'(1);
   assign primed = (fill_q >= need);
`endif

endmodule

// File: tb/tb_delay_line.sv
// Directed bench for delay_line: three instances cover CH=1/MAX_DEPTH=8, CH=2, and MAX_DEPTH=6.
module tb_delay_line;

   logic        clk = 1'b0;
   logic        rst, ce, flush, ivalid;
   logic [2:0]  tap_a, tap_b, tap_c;
   logic [7:0]  idata_a, idata_c, odata_a, odata_c;
   logic [15:0] idata_b, odata_b;
   logic        ovalid_a, ovalid_b, ovalid_c;
`ifdef DELAY_LINE_PRIMED_EN
   logic        primed_a, primed_b, primed_c;
`endif

   int tests_run = 0;
   int fails     = 0;

   always #5 clk = ~clk;

   delay_line #(.DATA_W(8), .CH(1), .MAX_DEPTH(8)) u_a (
      .clk(clk), .rst(rst), .ce(ce), .flush(flush), .tap(tap_a),
      .idata(idata_a), .ivalid(ivalid), .odata(odata_a), .ovalid(ovalid_a)
`ifdef DELAY_LINE_PRIMED_EN
      , .primed(primed_a)
`endif
   );

   delay_line #(.DATA_W(8), .CH(2), .MAX_DEPTH(8)) u_b (
      .clk(clk), .rst(rst), .ce(ce), .flush(flush), .tap(tap_b),
      .idata(idata_b), .ivalid(ivalid), .odata(odata_b), .ovalid(ovalid_b)
`ifdef DELAY_LINE_PRIMED_EN
      , .primed(primed_b)
`endif
   );

   delay_line #(.DATA_W(8), .CH(1), .MAX_DEPTH(6)) u_c (
      .clk(clk), .rst(rst), .ce(ce), .flush(flush), .tap(tap_c),
      .idata(idata_c), .ivalid(ivalid), .odata(odata_c), .ovalid(ovalid_c)
`ifdef DELAY_LINE_PRIMED_EN
      , .primed(primed_c)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; ce = 1'b0; flush = 1'b0; ivalid = 1'b0;
      idata_a = '0; idata_b = '0; idata_c = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         tap_a = 3'(k); tap_b = 3'(k); tap_c = 3'(k);
         #1;
         tests_run++;
         if (odata_a !== 8'h00 || ovalid_a !== 1'b0 || odata_b !== 16'h0000 || ovalid_b !== 1'b0 ||
             odata_c !== 8'h00 || ovalid_c !== 1'b0) begin
            fails++;
            $display("FAIL reset tap=%0d: got a=%h/%b b=%h/%b c=%h/%b, want all zero", k,
                     odata_a, ovalid_a, odata_b, ovalid_b, odata_c, ovalid_c);
         end
      end
   endtask

   task automatic test_basic();
      logic [7:0] exp_d [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
      logic       exp_v [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [7:0] in_d  [6] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
      do_reset();
      tap_a = 3'd2; ce = 1'b1;
      for (int i = 0; i < 6; i++) begin
         idata_a = in_d[i]; ivalid = (i < 3);
         tick();
         tests_run++;
         if (ovalid_a !== exp_v[i] || (exp_v[i] && odata_a !== exp_d[i])) begin
            fails++;
            $display("FAIL basic cycle %0d: got %h/%b, want %h/%b", i + 1, odata_a, ovalid_a,
                     exp_d[i], exp_v[i]);
         end
      end
   endtask

   task automatic test_ce();
      logic       ce_s  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [7:0] in_d  [7] = '{8'h11, 8'hEE, 8'h22, 8'hEE, 8'h33, 8'hEE, 8'h00};
      logic       in_v  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [7:0] exp_d [7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h11, 8'h22};
      logic       exp_v [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      do_reset();
      tap_a = 3'd2;
      for (int i = 0; i < 7; i++) begin
         ce = ce_s[i]; idata_a = in_d[i]; ivalid = in_v[i];
         tick();
         tests_run++;
         if (ovalid_a !== exp_v[i] || (exp_v[i] && odata_a !== exp_d[i])) begin
            fails++;
            $display("FAIL ce_gating step %0d: got %h/%b, want %h/%b", i, odata_a, ovalid_a,
                     exp_d[i], exp_v[i]);
         end
      end
      ce = 1'b0;
   endtask

   task automatic test_bit_exact();
      logic [15:0] pat [2] = '{16'h807F, 16'hA55A};
      do_reset();
      tap_b = 3'd0; ce = 1'b1; ivalid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         idata_b = pat[i];
         tick();
         tests_run++;
         if (odata_b !== pat[i] || ovalid_b !== 1'b1) begin
            fails++;
            $display("FAIL bit_exact %0d: got %h/%b, want %h/1", i, odata_b, ovalid_b, pat[i]);
         end
      end
      ce = 1'b0; ivalid = 1'b0;
   endtask

   task automatic test_flush();
      logic [7:0] exp_d;
      do_reset();
      ce = 1'b1; ivalid = 1'b1;
      for (int j = 0; j < 8; j++) begin
         idata_a = 8'h10 + 8'(j);
         tick();
      end
      flush = 1'b1; idata_a = 8'h99;
      tick();
      flush = 1'b0; ce = 1'b0; ivalid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tap_a = 3'(k);
         #1;
         exp_d = (k == 0) ? 8'h99 : 8'h18 - 8'(k);
         tests_run++;
         if (ovalid_a !== 1'b0 || odata_a !== exp_d) begin
            fails++;
            $display("FAIL flush tap=%0d: got %h/%b, want %h/0", k, odata_a, ovalid_a, exp_d);
         end
      end
      // Flush without ce: valid drops, data holds.
      tap_a = 3'd0; ce = 1'b1; ivalid = 1'b1; idata_a = 8'h55;
      tick();
      ce = 1'b0; ivalid = 1'b0; idata_a = 8'hAA; flush = 1'b1;
      tick();
      flush = 1'b0;
      tests_run++;
      if (odata_a !== 8'h55 || ovalid_a !== 1'b0) begin
         fails++;
         $display("FAIL flush_no_ce: got %h/%b, want 55/0", odata_a, ovalid_a);
      end
   endtask

   task automatic test_tap();
      do_reset();
      ce = 1'b1; ivalid = 1'b1;
      for (int j = 0; j < 8; j++) begin
         idata_a = 8'h20 + 8'(j);
         idata_c = 8'h30 + 8'(j);
         tick();
      end
      ce = 1'b0; ivalid = 1'b0;
      tap_a = 3'd7; tap_c = 3'd7;
      #1;
      tests_run++;
      if (odata_a !== 8'h20 || ovalid_a !== 1'b1) begin
         fails++;
         $display("FAIL tap7: got %h/%b, want 20/1", odata_a, ovalid_a);
      end
      tests_run++;
      if (odata_c !== 8'h32 || ovalid_c !== 1'b1) begin
         fails++;
         $display("FAIL clamp_tap7: got %h/%b, want 32/1", odata_c, ovalid_c);
      end
      tap_a = 3'd1; tap_c = 3'd4;
      #1;
      tests_run++;
      if (odata_a !== 8'h26 || ovalid_a !== 1'b1) begin
         fails++;
         $display("FAIL tap_switch_1: got %h/%b, want 26/1", odata_a, ovalid_a);
      end
      tests_run++;
      if (odata_c !== 8'h33) begin
         fails++;
         $display("FAIL tap_c4: got %h, want 33", odata_c);
      end
      tap_c = 3'd6;
      #1;
      tests_run++;
      if (odata_c !== 8'h32) begin
         fails++;
         $display("FAIL clamp_tap6: got %h, want 32", odata_c);
      end
      tap_a = 3'd7;
      #1;
      tests_run++;
      if (odata_a !== 8'h20) begin
         fails++;
         $display("FAIL tap_back_7: got %h, want 20", odata_a);
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      ce = 1'b1; ivalid = 1'b1;
      for (int j = 0; j < 5; j++) begin
         idata_a = 8'h40 + 8'(j);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0; ivalid = 1'b0; idata_a = 8'h00;
      for (int k = 0; k < 8; k++) begin
         tap_a = 3'(k);
         #1;
         tests_run++;
         if (odata_a !== 8'h00 || ovalid_a !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid tap=%0d: got %h/%b, want 00/0", k, odata_a, ovalid_a);
         end
      end
      for (int i = 0; i < 8; i++) begin
         tap_a = 3'(i);
         tick();
         tests_run++;
         if (ovalid_a !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_drain %0d: got ovalid=%b, want 0", i, ovalid_a);
         end
      end
      ce = 1'b0;
   endtask

`ifdef DELAY_LINE_PRIMED_EN
   task automatic test_primed();
      do_reset();
      tap_a = 3'd3; ce = 1'b1; ivalid = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         idata_a = 8'(k);
         tick();
         tests_run++;
         if (primed_a !== (k >= 4) || ovalid_a !== (k >= 4)) begin
            fails++;
            $display("FAIL primed k=%0d: got primed=%b ovalid=%b, want %b", k, primed_a, ovalid_a,
                     (k >= 4));
         end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0; ce = 1'b0; ivalid = 1'b0;
      tests_run++;
      if (primed_a !== 1'b0 || ovalid_a !== 1'b0 || odata_a !== 8'h00) begin
         fails++;
         $display("FAIL primed_rst: got primed=%b ovalid=%b odata=%h, want 0/0/00", primed_a,
                  ovalid_a, odata_a);
      end
   endtask
`endif

   initial begin
      tap_a = '0; tap_b = '0; tap_c = '0;
      test_reset();
      test_basic();
      test_ce();
      test_bit_exact();
      test_flush();
      test_tap();
      test_reset_midstream();
`ifdef DELAY_LINE_PRIMED_EN
      test_primed();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/delay_line.md
DELAY_LINE -- requirements
Module: delay_line

Interface
REQ-001 SHALL have parameter DATA_W, default 8: bit width of one channel sample.
REQ-002 SHALL have parameter CH, default 1: number of parallel channels sharing one delay.
REQ-003 SHALL have parameter MAX_DEPTH, default 8, legal range 2..64: the maximum delay in ce-qualified cycles.
REQ-004 SHALL define TAP_W = clog2(MAX_DEPTH) as a derived local constant.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port ce, input, 1 bit: clock enable; the line advances only when ce=1.
REQ-008 SHALL have port flush, input, 1 bit: synchronous clear of valid state.
REQ-009 SHALL have port tap, input, TAP_W bits: selects a delay of tap+1 stages.
REQ-010 SHALL have port idata, input, CH*DATA_W bits: signed samples, channel k at [k*DATA_W +: DATA_W].
REQ-011 SHALL have port ivalid, input, 1 bit: idata is qualified.
REQ-012 SHALL have port odata, output, CH*DATA_W bits: the delayed samples.
REQ-013 SHALL have port ovalid, output, 1 bit: odata is qualified.

Function
REQ-014 SHALL hold a chain of MAX_DEPTH stages, each holding CH*DATA_W data bits plus 1 valid bit.
REQ-015 SHALL, when ce=1: load stage0 with idata/ivalid, and load stage[i] with stage[i-1] for i=1..MAX_DEPTH-1.
REQ-016 SHALL, when ce=0, hold all stages unchanged regardless of idata, ivalid and tap.
REQ-017 SHALL drive odata/ovalid combinationally from stage[min(tap, MAX_DEPTH-1)]; delay = tap+1 ce-cycles.
REQ-018 SHALL clamp tap values of MAX_DEPTH or more (non-power-of-2 MAX_DEPTH) to stage MAX_DEPTH-1.
REQ-019 SHALL make a tap change take effect on odata/ovalid in the same cycle, with no stage contents altered.
REQ-020 SHALL pass data through bit-exact: no sign extension, rounding or per-channel skew.
REQ-021 SHALL, on flush=1, clear all valid bits at the next edge, with or without ce.
REQ-022 SHALL, on flush=1 with ce=1, still shift the data stages and discard the incoming ivalid, so stage0 valid=0.
REQ-023 SHALL apply priority rst > flush > ce.

Reset
REQ-024 SHALL, on rst=1 at a clk edge, clear all data stages to 0 and all valid bits to 0, independent of ce.
REQ-025 SHALL read odata=0 and ovalid=0 in the cycle after reset, for any tap.
REQ-026 SHALL, on reset mid-stream, lose all in-flight samples, with no output of them after reset.

Configuration
REQ-027 SHALL, with macro DELAY_LINE_PRIMED_EN defined, add output port primed (1 bit) and an internal fill counter of width clog2(MAX_DEPTH+1).
REQ-028 SHALL increment the fill counter on ce=1 with ivalid=1 and flush=0, saturating at MAX_DEPTH; rst or flush clears it to 0.
REQ-029 SHALL drive primed = (fill counter >= min(tap, MAX_DEPTH-1)+1), combinationally, with reset value 0.
REQ-030 SHALL, without DELAY_LINE_PRIMED_EN, omit the primed port and the counter, with all other behaviour identical.

Structure
REQ-031 SHALL place the TAP_W derivation function and the channel slice macro/function in shared package delay_pkg.
REQ-032 SHALL use one sub-module, delay_stage, containing one register of DATA_W*CH+1 bits with clk/rst/ce/clr, instantiated MAX_DEPTH times by generate.

Verification
REQ-033 SHALL cover: DATA_W=8, CH=1, tap=2, ce=1, push 0x11,0x22,0x33 valid -> 0x11 on odata with ovalid=1 exactly 3 cycles after entry.
REQ-034 SHALL cover: the same stream with ce toggling 1,0,1,0 -> each output advances only on ce=1 cycles, with delay counted in ce-cycles.
REQ-035 SHALL cover: CH=2, idata={8'h80,8'h7F}, tap=0 -> next cycle odata={8'h80,8'h7F}, bit-exact and sign-preserved.
REQ-036 SHALL cover: 8 valid samples, then flush=1 with ce=1 -> next cycle all ovalid=0 for tap 0..7, and data still shifted.
REQ-037 SHALL cover: with the line full, tap switched 7->1 -> odata equals stage1 contents in the same cycle; MAX_DEPTH=6, tap=7 -> stage5 output.
REQ-038 SHALL cover: DELAY_LINE_PRIMED_EN, tap=3 -> primed rises after the 4th valid ce-cycle; rst mid-stream -> primed=0, ovalid=0, odata=0 next cycle.
